// File: rtl/adc_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_pkg
// Brief    : Shared types and constants for the AD9648-style SPI responder.
// Revision : 1.0 - initial release
// ============================================================================
package adc_spi_pkg;

  // Frame progress through one chip-select window
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INSTR   = 3'd1,
    ST_DATA_WR = 3'd2,
    ST_DATA_RD = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Instruction word layout
  localparam int INSTR_LEN    = 16;
  localparam int INSTR_RW_BIT = 15;
  localparam int INSTR_LEN_HI = 14;
  localparam int INSTR_LEN_LO = 13;
  localparam int ADDR_W       = 13;

  localparam logic [ADDR_W-1:0] ADDR_CHIP_ID = 13'h001;

  // W1W0 byte-count field encodings
  localparam logic [1:0] LEN_1      = 2'b00;
  localparam logic [1:0] LEN_2      = 2'b01;
  localparam logic [1:0] LEN_3      = 2'b10;
  localparam logic [1:0] LEN_STREAM = 2'b11;

  // Number of data bytes for a fixed-length frame; streaming returns 0
  function automatic logic [1:0] byte_count(input logic [1:0] len);
    case (len)
      LEN_1:   byte_count = 2'd1;
      LEN_2:   byte_count = 2'd2;
      LEN_3:   byte_count = 2'd3;
      default: byte_count = 2'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_spi_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_responder_if
// Brief    : SPI pins plus register-write side band of the ADC responder.
// Revision : 1.0 - initial release
// ============================================================================
interface adc_spi_responder_if;
  import adc_spi_pkg::*;

  logic              csb;
  logic              sclk;
  logic              sdi;
  logic              sdo;
  logic              sdo_oe;
  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [7:0]        reg_wr_data;
  logic              busy;
  logic              frame_error;

  modport master (
    output csb, sclk, sdi,
    input  sdo, sdo_oe, reg_wr_en, reg_wr_addr, reg_wr_data, busy, frame_error
  );

  modport slave (
    input  csb, sclk, sdi,
    output sdo, sdo_oe, reg_wr_en, reg_wr_addr, reg_wr_data, busy, frame_error
  );

endinterface
`default_nettype wire

// File: rtl/spi_pin_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_pin_sync
// Brief    : Multi-stage synchronizer for one SPI pin with optional edge
//            detection. Resets low so a csb held low across reset is never
//            mistaken for a fresh frame start.
// Revision : 1.0 - initial release
// ============================================================================
module spi_pin_sync #(
  parameter int STAGES = 2,
  parameter bit EDGES  = 1'b1
) (
  input  wire logic sys_clk,
  input  wire logic reset_n,
  input  wire logic i_pin,
  output logic      o_level,
  output logic      o_rise,
  output logic      o_fall
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous pin through the synchronizer chain
  always_ff @(posedge sys_clk) begin
    if (!reset_n) r_chain <= '0;
    else          r_chain <= {r_chain[STAGES-2:0], i_pin};
  end

  assign o_level = r_chain[STAGES-1];

  generate
    if (EDGES) begin : g_edges
      logic r_prev;

      // Remember the previous synchronized level for edge detection
      always_ff @(posedge sys_clk) begin
        if (!reset_n) r_prev <= 1'b0;
        else          r_prev <= o_level;
      end

      assign o_rise = o_level & ~r_prev;
      assign o_fall = ~o_level & r_prev;
    end else begin : g_no_edges
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_responder
// Brief    : SPI responder emulating the AD9648 serial port register map.
//            Mode 0, MSB first, 16-bit instruction then data bytes with a
//            decrementing address. All pins oversampled in sys_clk.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_responder
  import adc_spi_pkg::*;
#(
  parameter int         ADDR_BITS   = 5,
  parameter logic [7:0] CHIP_ID     = 8'h88,
  parameter int         SYNC_STAGES = 2
) (
  input  wire logic           sys_clk,
  input  wire logic           reset_n,
  adc_spi_responder_if.slave  spi
);

  localparam int NUM_REGS = 1 << ADDR_BITS;

  logic w_csb, w_csb_fall, w_unused_csb_rise;
  logic w_sclk, w_sclk_rise, w_sclk_fall;
  logic w_sdi, w_unused_sdi_rise, w_unused_sdi_fall;
  logic w_unused_sclk_level;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_csb (
    .sys_clk(sys_clk), .reset_n(reset_n), .i_pin(spi.csb),
    .o_level(w_csb), .o_rise(w_unused_csb_rise), .o_fall(w_csb_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b1)) u_sync_sclk (
    .sys_clk(sys_clk), .reset_n(reset_n), .i_pin(spi.sclk),
    .o_level(w_sclk), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall));

  spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGES(1'b0)) u_sync_sdi (
    .sys_clk(sys_clk), .reset_n(reset_n), .i_pin(spi.sdi),
    .o_level(w_sdi), .o_rise(w_unused_sdi_rise), .o_fall(w_unused_sdi_fall));

  assign w_unused_sclk_level = w_sclk;

  state_t                r_state, w_next_state;
  logic [3:0]            r_bit_cnt;
  logic [INSTR_LEN-2:0]  r_shift;
  logic [ADDR_W-1:0]     r_addr;
  logic [1:0]            r_bytes_left;
  logic                  r_stream;
  logic                  r_rd_load;
  logic [7:0]            r_sdo_shift;
  logic                  r_sdo, r_sdo_oe;
  logic                  r_wr_en;
  logic [ADDR_W-1:0]     r_wr_addr;
  logic [7:0]            r_wr_data;
  logic                  r_frame_error;
  logic [7:0]            r_regs [NUM_REGS];

  logic [INSTR_LEN-1:0]  w_instr;
  logic                  w_abort, w_instr_done, w_byte_done, w_last_byte;
  logic                  w_addr_in_range;
  logic [7:0]            w_rd_byte;

  assign w_instr         = {r_shift, w_sdi};
  assign w_last_byte     = !r_stream && (r_bytes_left == 2'd1);
  assign w_addr_in_range = (r_addr[ADDR_W-1:ADDR_BITS] == '0);

  // State register
  always_ff @(posedge sys_clk) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // Next-state decode plus frame-boundary events; csb high always wins
  always_comb begin
    w_next_state = r_state;
    w_abort      = 1'b0;
    w_instr_done = 1'b0;
    w_byte_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_csb_fall) w_next_state = ST_INSTR;
      end
      ST_INSTR: begin
        if (w_csb) begin
          w_next_state = ST_IDLE;
          w_abort      = 1'b1;
        end else if (w_sclk_rise && r_bit_cnt == 4'(INSTR_LEN - 1)) begin
          w_instr_done = 1'b1;
          w_next_state = w_instr[INSTR_RW_BIT] ? ST_DATA_RD : ST_DATA_WR;
        end
      end
      ST_DATA_WR, ST_DATA_RD: begin
        if (w_csb) begin
          w_next_state = ST_IDLE;
          w_abort      = (r_bit_cnt != 4'd0);
        end else if (w_sclk_rise && r_bit_cnt == 4'd7) begin
          w_byte_done = 1'b1;
          if (w_last_byte) w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        if (w_csb) w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Read mux: chip ID is fixed, out-of-range addresses read as zero
  always_comb begin
    w_rd_byte = 8'h00;
    if (r_addr == ADDR_CHIP_ID)  w_rd_byte = CHIP_ID;
    else if (w_addr_in_range)    w_rd_byte = r_regs[r_addr[ADDR_BITS-1:0]];
  end

  // Bit/byte counters, shifters, register file and serial output
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_addr        <= '0;
      r_bytes_left  <= '0;
      r_stream      <= 1'b0;
      r_rd_load     <= 1'b0;
      r_sdo_shift   <= '0;
      r_sdo         <= 1'b0;
      r_sdo_oe      <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_frame_error <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= 8'h00;
    end else begin
      r_wr_en       <= 1'b0;
      r_frame_error <= w_abort;
      if (r_state == ST_IDLE) begin
        r_bit_cnt <= '0;
        r_rd_load <= 1'b0;
      end else if (w_csb) begin
        r_bit_cnt <= '0;
        r_rd_load <= 1'b0;
        r_sdo     <= 1'b0;
        r_sdo_oe  <= 1'b0;
      end else if (w_sclk_rise && r_state != ST_DONE) begin
        r_shift   <= w_instr[INSTR_LEN-2:0];
        r_bit_cnt <= (w_instr_done || w_byte_done) ? 4'd0 : r_bit_cnt + 4'd1;
        if (w_instr_done) begin
          r_addr       <= w_instr[ADDR_W-1:0];
          r_stream     <= (w_instr[INSTR_LEN_HI:INSTR_LEN_LO] == LEN_STREAM);
          r_bytes_left <= byte_count(w_instr[INSTR_LEN_HI:INSTR_LEN_LO]);
          r_rd_load    <= w_instr[INSTR_RW_BIT];
        end
        if (w_byte_done) begin
          r_addr <= r_addr - 13'd1;
          if (!r_stream) r_bytes_left <= r_bytes_left - 2'd1;
          if (r_state == ST_DATA_WR) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_addr;
            r_wr_data <= w_instr[7:0];
            if (w_addr_in_range && r_addr != ADDR_CHIP_ID)
              r_regs[r_addr[ADDR_BITS-1:0]] <= w_instr[7:0];
          end else if (!w_last_byte) begin
            r_rd_load <= 1'b1;
          end
        end
      end else if (w_sclk_fall && r_state == ST_DATA_RD) begin
        if (r_rd_load) begin
          r_sdo       <= w_rd_byte[7];
          r_sdo_shift <= {w_rd_byte[6:0], 1'b0};
          r_sdo_oe    <= 1'b1;
          r_rd_load   <= 1'b0;
        end else begin
          r_sdo       <= r_sdo_shift[7];
          r_sdo_shift <= {r_sdo_shift[6:0], 1'b0};
        end
      end
    end
  end

  assign spi.sdo         = r_sdo;
  assign spi.sdo_oe      = r_sdo_oe;
  assign spi.reg_wr_en   = r_wr_en;
  assign spi.reg_wr_addr = r_wr_addr;
  assign spi.reg_wr_data = r_wr_data;
  assign spi.busy        = (r_state != ST_IDLE);
  assign spi.frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_responder
// Brief    : Self-checking bench for adc_spi_responder. A byte-level model of
//            the register map predicts write strobes and read data.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_responder;
  import adc_spi_pkg::*;

  localparam int HALF = 8;   // sys_clk cycles per sclk half period

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  adc_spi_responder_if spi ();

  adc_spi_responder #(.ADDR_BITS(5), .CHIP_ID(8'h88), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk),
    .reset_n(reset_n),
    .spi    (spi)
  );

  typedef struct packed {
    logic [12:0] a;
    logic [7:0]  d;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_seen = 0;
  logic [7:0]  mdl_mem [32];
  wr_t         exp_wr [$];
  wr_t         mon_e;
  logic [7:0]  tx [8];
  logic [7:0]  rx [8];
  logic        so_bit;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model read: chip ID at 0x001, 32 implemented bytes, zero elsewhere
  function automatic logic [7:0] mdl_read(input logic [12:0] a);
    if (a == 13'h001) return 8'h88;
    if (a < 13'd32)   return mdl_mem[a[4:0]];
    return 8'h00;
  endfunction

  // Compare process: every write strobe must match the next predicted one
  always @(negedge sys_clk) begin
    if (spi.frame_error === 1'b1) err_seen++;
    if (spi.reg_wr_en !== 1'b0) begin
      if (exp_wr.size() == 0) begin
        check("wr_unexpected", {31'd0, spi.reg_wr_en}, 32'd0);
      end else begin
        mon_e = exp_wr.pop_front();
        check("wr_addr", {19'd0, spi.reg_wr_addr}, {19'd0, mon_e.a});
        check("wr_data", {24'd0, spi.reg_wr_data}, {24'd0, mon_e.d});
      end
    end
  end

  task automatic sbit(input logic b, output logic so);
    spi.sdi = b;
    repeat (HALF) @(negedge sys_clk);
    so = spi.sdo;
    spi.sclk = 1'b1;
    repeat (HALF) @(negedge sys_clk);
    spi.sclk = 1'b0;
  endtask

  task automatic cs_low();
    spi.csb = 1'b0;
    repeat (HALF) @(negedge sys_clk);
  endtask

  task automatic cs_high();
    repeat (HALF) @(negedge sys_clk);
    spi.csb = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  task automatic send_instr(input logic [15:0] instr);
    logic so;
    for (int i = 15; i >= 0; i--) sbit(instr[i], so);
  endtask

  // Write frame of nbits data bits from tx[]; model predicts strobes/storage
  task automatic spi_write(input string tag, input logic [15:0] instr, input int nbits);
    int len, full, err0;
    logic [12:0] a;
    logic so;
    len  = (instr[14:13] == 2'b11) ? 1000 : int'(instr[14:13]) + 1;
    full = nbits / 8;
    a    = instr[12:0];
    for (int k = 0; k < full && k < len; k++) begin
      exp_wr.push_back({a, tx[k]});
      if (a != 13'h001 && a < 13'd32) mdl_mem[a[4:0]] = tx[k];
      a = a - 13'd1;
    end
    err0 = err_seen;
    cs_low();
    send_instr(instr);
    check({tag, "_busy"}, {31'd0, spi.busy}, 32'd1);
    for (int k = 0; k < nbits; k++) sbit(tx[k / 8][7 - (k % 8)], so);
    check({tag, "_oe_wr"}, {31'd0, spi.sdo_oe}, 32'd0);
    cs_high();
    check({tag, "_strobes_left"}, exp_wr.size(), 32'd0);
    check({tag, "_frame_error"}, err_seen - err0, (nbits % 8 != 0) ? 32'd1 : 32'd0);
    check({tag, "_busy_end"}, {31'd0, spi.busy}, 32'd0);
  endtask

  // Read frame of nbytes; each byte compared against the model
  task automatic spi_read(input string tag, input logic [15:0] instr, input int nbytes);
    int err0;
    logic [12:0] a;
    logic so;
    logic [7:0] b;
    a    = instr[12:0];
    err0 = err_seen;
    cs_low();
    send_instr(instr);
    for (int k = 0; k < nbytes; k++) begin
      for (int i = 7; i >= 0; i--) begin
        sbit(1'b0, so);
        b[i] = so;
      end
      rx[k] = b;
      check({tag, "_rd_byte"}, {24'd0, b}, {24'd0, mdl_read(a)});
      check({tag, "_oe_rd"}, {31'd0, spi.sdo_oe}, 32'd1);
      a = a - 13'd1;
    end
    cs_high();
    check({tag, "_oe_end"}, {31'd0, spi.sdo_oe}, 32'd0);
    check({tag, "_frame_error"}, err_seen - err0, 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int err0;
    spi.csb  = 1'b1;
    spi.sclk = 1'b0;
    spi.sdi  = 1'b0;
    for (int i = 0; i < 32; i++) mdl_mem[i] = 8'h00;

    // Reset state
    repeat (4) @(negedge sys_clk);
    check("rst_sdo",    {31'd0, spi.sdo},         32'd0);
    check("rst_sdo_oe", {31'd0, spi.sdo_oe},      32'd0);
    check("rst_wr_en",  {31'd0, spi.reg_wr_en},   32'd0);
    check("rst_wr_addr",{19'd0, spi.reg_wr_addr}, 32'd0);
    check("rst_wr_data",{24'd0, spi.reg_wr_data}, 32'd0);
    check("rst_busy",   {31'd0, spi.busy},        32'd0);
    check("rst_ferr",   {31'd0, spi.frame_error}, 32'd0);
    reset_n = 1'b1;
    repeat (6) @(negedge sys_clk);

    // 1/2: single write then readback
    tx[0] = 8'h25;
    spi_write("t1", 16'h0008, 8);
    spi_read("t2", 16'h8008, 1);
    check("t2_lit", {24'd0, rx[0]}, 32'h25);

    // 3: chip ID is read-only
    spi_read("t3a", 16'h8001, 1);
    check("t3a_lit", {24'd0, rx[0]}, 32'h88);
    tx[0] = 8'h00;
    spi_write("t3w", 16'h0001, 8);
    spi_read("t3b", 16'h8001, 1);
    check("t3b_lit", {24'd0, rx[0]}, 32'h88);

    // 4: streaming write of three bytes, 3-byte readback
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    spi_write("t4", 16'h600A, 24);
    spi_read("t4r", 16'hC00A, 3);
    check("t4_lit0", {24'd0, rx[0]}, 32'h11);
    check("t4_lit1", {24'd0, rx[1]}, 32'h22);
    check("t4_lit2", {24'd0, rx[2]}, 32'h33);

    // Address wrap 0x000 -> 0x1FFF and out-of-range handling
    tx[0] = 8'hAA; tx[1] = 8'hBB; tx[2] = 8'hCC;
    spi_write("wrap", 16'h6001, 24);
    spi_read("wrapr", 16'hA001, 2);
    check("wrap_lit0", {24'd0, rx[0]}, 32'h88);
    check("wrap_lit1", {24'd0, rx[1]}, 32'hBB);
    spi_read("oor", 16'h9FFF, 1);
    check("oor_lit", {24'd0, rx[0]}, 32'h00);

    // 5: aborted write after 5 data bits
    tx[0] = 8'hFF;
    spi_write("t5", 16'h0004, 5);
    spi_read("t5r", 16'h8004, 1);
    check("t5_lit", {24'd0, rx[0]}, 32'h00);

    // 6: reset during the read data phase
    cs_low();
    send_instr(16'h8008);
    sbit(1'b0, so_bit); sbit(1'b0, so_bit); sbit(1'b0, so_bit);
    check("t6_oe_before",   {31'd0, spi.sdo_oe}, 32'd1);
    check("t6_busy_before", {31'd0, spi.busy},   32'd1);
    err0 = err_seen;
    reset_n = 1'b0;
    @(negedge sys_clk);
    check("t6_oe_reset",   {31'd0, spi.sdo_oe}, 32'd0);
    check("t6_busy_reset", {31'd0, spi.busy},   32'd0);
    for (int i = 0; i < 32; i++) mdl_mem[i] = 8'h00;
    repeat (3) @(negedge sys_clk);
    reset_n = 1'b1;
    repeat (4) @(negedge sys_clk);
    check("t6_busy_held", {31'd0, spi.busy}, 32'd0);
    spi.csb = 1'b1;
    repeat (8) @(negedge sys_clk);
    check("t6_no_error", err_seen - err0, 32'd0);
    spi_read("t6r", 16'h8008, 1);
    check("t6_lit", {24'd0, rx[0]}, 32'h00);
    check("final_strobes_left", exp_wr.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
